// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU arbiter/controller.
//   - op class codes (op[4:3])
//   - ALU top-level select codes per class
//   - controller FSM state enum
package alu_ctrl_pkg;

  localparam int NUM_REQ = 2;
  localparam int OPW     = 5;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_SHIFT = 2'b10;

  localparam logic [2:0] SEL_ARITH = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b011;
  localparam logic [2:0] SEL_SHIFT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
// Ports:
//   op      in  5 : compact opcode, class in op[4:3], sub-op in op[2:0]
//   sel     out 3 : ALU class select
//   sel1    out 3 : arithmetic sub-op (000 when unused)
//   sel2    out 3 : logic sub-op (000 when unused)
//   sel3    out 3 : shift sub-op (000 when unused)
//   illegal out 1 : opcode not supported; all selects are 000 in that case
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] op,
  output logic [2:0]     sel,
  output logic [2:0]     sel1,
  output logic [2:0]     sel2,
  output logic [2:0]     sel3,
  output logic           illegal
);

  always_comb begin
    sel     = 3'b000;
    sel1    = 3'b000;
    sel2    = 3'b000;
    sel3    = 3'b000;
    illegal = 1'b0;
    case (op[4:3])
      CLS_ARITH: begin
        sel  = SEL_ARITH;
        sel1 = op[2:0];
      end
      CLS_LOGIC: begin
        if (op[2:0] == 3'd7) illegal = 1'b1;
        else begin
          sel  = SEL_LOGIC;
          sel2 = op[2:0];
        end
      end
      CLS_SHIFT: begin
        if (op[2]) illegal = 1'b1;
        else begin
          sel  = SEL_SHIFT;
          sel3 = op[2:0];
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter and controller sharing one combinational ALU between
// two requesters. Accepts a request in IDLE, drives the ALU for one cycle in
// EXEC, registers the result and presents it in RESP until handshaken.
// Optional build macro: ALU_ARB_ACC_EN adds a per-requester accumulator fed
// back through alu_in/alu_load_en.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready [2]  : per-requester request handshake
//   req_op/a/b/shift/use_acc : per-requester payload, lane i at [i*W +: W]
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data/rsp_id/rsp_err  : registered result, requester ID, illegal-op flag
//   alu_*                    : ALU control/operands (zero outside EXEC)
//   alu_result               : combinational ALU output
module alu_arb_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_op,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  input  logic [NUM_REQ*SW-1:0] req_shift,
  input  logic [NUM_REQ-1:0]    req_use_acc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_err,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  output logic [DW-1:0]         alu_in,
  output logic [2:0]            alu_sel,
  output logic [2:0]            alu_sel1,
  output logic [2:0]            alu_sel2,
  output logic [2:0]            alu_sel3,
  output logic [SW-1:0]         alu_shift,
  output logic                  alu_load_en,
  input  logic [DW-1:0]         alu_result
);

  // lane views of the flat request buses
  logic [NUM_REQ-1:0][OPW-1:0] op_v;
  logic [NUM_REQ-1:0][DW-1:0]  a_v, b_v;
  logic [NUM_REQ-1:0][SW-1:0]  sh_v;
  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;
  assign sh_v = req_shift;

  state_t         state, state_nxt;
  logic           last_grant;
  logic           grant_id;
  logic           any_req;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q, b_q;
  logic [SW-1:0]  sh_q;
  logic           id_q;
  logic           accept;

  logic [2:0] d_sel, d_sel1, d_sel2, d_sel3;
  logic       d_illegal;

  alu_op_decode u_dec (
    .op      (op_q),
    .sel     (d_sel),
    .sel1    (d_sel1),
    .sel2    (d_sel2),
    .sel3    (d_sel3),
    .illegal (d_illegal)
  );

  // under contention the requester not granted last wins
  always_comb begin
    any_req = |req_valid;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  assign accept    = (state == IDLE) && any_req && !rst;
  assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == RESP);

`ifdef ALU_ARB_ACC_EN
  logic [NUM_REQ-1:0][DW-1:0] acc_q;
  logic                       use_acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      use_acc_q <= 1'b0;
    end else begin
      if (accept) use_acc_q <= req_use_acc[grant_id];
      // every legal op refreshes its requester's accumulator
      if (state == EXEC && !d_illegal) acc_q[id_q] <= alu_result;
    end
  end
`else
  logic unused_use_acc;
  assign unused_use_acc = ^req_use_acc;
`endif

  // ALU drive: only in EXEC and only for legal ops, so an illegal op leaves
  // the ALU inputs quiet
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_in      = '0;
    alu_sel     = 3'b000;
    alu_sel1    = 3'b000;
    alu_sel2    = 3'b000;
    alu_sel3    = 3'b000;
    alu_shift   = '0;
    alu_load_en = 1'b0;
    if (state == EXEC && !d_illegal) begin
      alu_a     = a_q;
      alu_b     = b_q;
      alu_sel   = d_sel;
      alu_sel1  = d_sel1;
      alu_sel2  = d_sel2;
      alu_sel3  = d_sel3;
      alu_shift = sh_q;
`ifdef ALU_ARB_ACC_EN
      if (use_acc_q) begin
        alu_in      = acc_q[id_q];
        alu_load_en = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      id_q       <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= op_v[grant_id];
        a_q        <= a_v[grant_id];
        b_q        <= b_v[grant_id];
        sh_q       <= sh_v[grant_id];
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_data <= d_illegal ? '0 : alu_result;
        rsp_err  <= d_illegal;
        rsp_id   <= id_q;
      end
    end
  end

endmodule
